// File: rtl/sim_sweep_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sim_sweep_gen
//
// Simulated radar sweep generator. It turns the divided bearing clock (clk273)
// and range clock (clk200k) into an azimuth count with ACP/ARP pulses, a
// per-bearing range sweep with a trigger, and a synthetic target video bit.
// This lets the display/processing chain run without an antenna or receiver.
// Both slow clocks are sampled as levels in the clk domain and edge-detected.
// They are never used as clocks.
//
// Ports
//   clk             system clock (33 MHz)
//   reset           asynchronous, active-low reset
//   clk273          bearing clock level, synchronous to clk
//   clk200k         range clock level, synchronous to clk
//   enable          run control; low freezes bearing and aborts the sweep
//   target_bearing  target start bearing (latched at sweep start)
//   target_range    target start range cell (latched at sweep start)
//   acp             one-clk pulse per bearing step
//   arp             one-clk pulse when bearing wraps to 0
//   trig            one-clk pulse at sweep start
//   bearing         current bearing
//   range_cell      current range cell
//   sweep_busy      high while a sweep is in progress
//   video           synthetic target video (registered)
// -----------------------------------------------------------------------------
module sim_sweep_gen #(
  parameter int ACP_COUNT   = 4096,
  parameter int BEAR_W      = 12,
  parameter int RANGE_CELLS = 512,
  parameter int RANGE_W     = 9,
  parameter int TGT_BW      = 4,
  parameter int TGT_RW      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk273,
  input  logic               clk200k,
  input  logic               enable,
  input  logic [BEAR_W-1:0]  target_bearing,
  input  logic [RANGE_W-1:0] target_range,
  output logic               acp,
  output logic               arp,
  output logic               trig,
  output logic [BEAR_W-1:0]  bearing,
  output logic [RANGE_W-1:0] range_cell,
  output logic               sweep_busy,
  output logic               video
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [BEAR_W-1:0]  BEAR_LAST  = BEAR_W'(ACP_COUNT - 1);
  localparam logic [RANGE_W-1:0] RANGE_LAST = RANGE_W'(RANGE_CELLS - 1);
  localparam logic [RANGE_W:0]   RANGE_EXT  = (RANGE_W+1)'(TGT_RW - 1);
  localparam logic [BEAR_W:0]    BEAR_MOD   = (BEAR_W+1)'(ACP_COUNT);
  localparam logic [BEAR_W:0]    BEAR_WIN   = (BEAR_W+1)'(TGT_BW);

  state_t             state;
  logic               c273_d;
  logic               c200_d;
  logic [BEAR_W-1:0]  tb_q;     // latched target bearing
  logic [RANGE_W-1:0] tr_q;     // latched target range

  logic               tick273;
  logic               tick200;
  logic               step;
  logic [BEAR_W-1:0]  bear_next;
  logic [RANGE_W:0]   r_cur;
  logic [RANGE_W:0]   r_lo;
  logic [RANGE_W:0]   r_hi;
  logic [BEAR_W:0]    b_diff;
  logic [BEAR_W:0]    b_off;
  logic               hit;

  // Rising-edge detect against last clk's sample of each input level.
  assign tick273 = clk273  & ~c273_d;
  assign tick200 = clk200k & ~c200_d;
  assign step    = tick273 & enable;

  assign sweep_busy = (state == SWEEP);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    bear_next = bearing + 1'b1;
    if (bearing == BEAR_LAST) bear_next = '0;

    // Range window is evaluated one bit wider so tr+TGT_RW-1 never wraps.
    r_cur = {1'b0, range_cell};
    r_lo  = {1'b0, tr_q};
    r_hi  = r_lo + RANGE_EXT;

    // Bearing offset from the target, folded into 0..ACP_COUNT-1 so the
    // window wraps through bearing 0.
    b_diff = {1'b0, bearing} - {1'b0, tb_q};
    b_off  = b_diff;
    if (b_diff[BEAR_W]) b_off = b_diff + BEAR_MOD;

    hit = (state == SWEEP) && (r_cur >= r_lo) && (r_cur <= r_hi) &&
          (b_off < BEAR_WIN);
  end

  // NOTE: every register, including the latched targets, is cleared by the
  // asynchronous reset so outputs are defined the instant reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c273_d     <= 1'b0;
      c200_d     <= 1'b0;
      state      <= IDLE;
      bearing    <= '0;
      range_cell <= '0;
      tb_q       <= '0;
      tr_q       <= '0;
      acp        <= 1'b0;
      arp        <= 1'b0;
      trig       <= 1'b0;
      video      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      c273_d <= clk273;
      c200_d <= clk200k;

      acp  <= step;
      trig <= step;
      arp  <= step && (bear_next == '0);
      if (step) bearing <= bear_next;

      // Video reflects the state/bearing/range present before this edge.
      video <= hit;

      // Restart has priority over a coincident range tick.
      if (!enable) begin
        state <= IDLE;
      end else if (tick273) begin
        state      <= SWEEP;
        range_cell <= '0;
        tb_q       <= target_bearing;
        tr_q       <= target_range;
      end else if (state == SWEEP && tick200) begin
        if (range_cell == RANGE_LAST) state <= IDLE;
        else                          range_cell <= range_cell + 1'b1;
      end
    end
  end

endmodule
